// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter for performance debug.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid_r, main_valid_s;
  logic [CTRL_W-1:0] main_ctrl_r, main_ctrl_s;
  logic [DATA_W-1:0] main_data_r, main_data_s;
  logic              skid_valid_r, skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_r, skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_r, skid_data_s;
  logic [1:0]        occ_r, occ_s;
  logic [CNT_W-1:0]  stall_r, stall_s;
  logic              it_s, ot_s;

  // Next-state for both entries; invalid entries always carry zero ctrl/data.
  always_comb begin
    it_s         = in_valid & ~skid_valid_r;
    ot_s         = main_valid_r & out_ready;
    main_valid_s = main_valid_r;
    main_ctrl_s  = main_ctrl_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_ctrl_s  = skid_ctrl_r;
    skid_data_s  = skid_data_r;
    if (flush) begin
      main_valid_s = 1'b0;
      main_ctrl_s  = {CTRL_W{1'b0}};
      main_data_s  = {DATA_W{1'b0}};
      skid_valid_s = 1'b0;
      skid_ctrl_s  = {CTRL_W{1'b0}};
      skid_data_s  = {DATA_W{1'b0}};
    end else begin
      case ({main_valid_r, skid_valid_r})
        2'b00: begin
          if (it_s) begin
            main_valid_s = 1'b1;
            main_ctrl_s  = in_ctrl;
            main_data_s  = in_data;
          end else begin
            main_valid_s = 1'b0;
          end
        end
        2'b10: begin
          if (it_s && ot_s) begin
            main_ctrl_s = in_ctrl;
            main_data_s = in_data;
          end else if (ot_s) begin
            main_valid_s = 1'b0;
            main_ctrl_s  = {CTRL_W{1'b0}};
            main_data_s  = {DATA_W{1'b0}};
          end else if (it_s) begin
            skid_valid_s = 1'b1;
            skid_ctrl_s  = in_ctrl;
            skid_data_s  = in_data;
          end else begin
            main_valid_s = 1'b1;
          end
        end
        2'b11: begin
          if (ot_s) begin
            main_ctrl_s  = skid_ctrl_r;
            main_data_s  = skid_data_r;
            skid_valid_s = 1'b0;
            skid_ctrl_s  = {CTRL_W{1'b0}};
            skid_data_s  = {DATA_W{1'b0}};
          end else begin
            skid_valid_s = 1'b1;
          end
        end
        default: begin
          // Skid-only is unreachable; recover to EMPTY if it ever appears.
          main_valid_s = 1'b0;
          main_ctrl_s  = {CTRL_W{1'b0}};
          main_data_s  = {DATA_W{1'b0}};
          skid_valid_s = 1'b0;
          skid_ctrl_s  = {CTRL_W{1'b0}};
          skid_data_s  = {DATA_W{1'b0}};
        end
      endcase
    end
    occ_s = {1'b0, main_valid_s} + {1'b0, skid_valid_s};
    if (main_valid_r && !out_ready && (stall_r != CNT_MAX)) begin
      stall_s = stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_s = stall_r;
    end
  end

  // State registers with synchronous reset taking priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_r <= 1'b0;
      main_ctrl_r  <= {CTRL_W{1'b0}};
      main_data_r  <= {DATA_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= {CTRL_W{1'b0}};
      skid_data_r  <= {DATA_W{1'b0}};
      occ_r        <= 2'd0;
      stall_r      <= {CNT_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      main_ctrl_r  <= main_ctrl_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_ctrl_r  <= skid_ctrl_s;
      skid_data_r  <= skid_data_s;
      occ_r        <= occ_s;
      stall_r      <= stall_s;
    end
  end

  assign in_ready     = ~skid_valid_r;
  assign out_valid    = main_valid_r;
  assign out_ctrl     = main_ctrl_r;
  assign out_data     = main_data_r;
  assign occupancy    = occ_r;
  assign stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: stimulus queues expected beats, a
// negedge monitor pops and compares each delivered beat.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cycles;
  logic [39:0] exp_q[$];
  logic [39:0] exp_beat;
  int          total = 0;
  int          bad = 0;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = 32'h0; in_ctrl = 8'h0;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: compare every delivered beat against the scoreboard, and check bubbles are zero.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_data, 32'h0);
          total++; bad++;
          $display("FAIL unexpected_beat: got beat 0x%0h with no expected entry", out_data);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat_data", out_data, exp_beat[31:0]);
          check("beat_ctrl", {24'h0, out_ctrl}, {24'h0, exp_beat[39:32]});
        end
      end else if (!out_valid) begin
        check("bubble_zero", {24'h0, out_ctrl} | out_data, 32'h0);
      end
    end
  end

  initial begin
    // Reset with a beat offered: nothing may be captured.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_ctrl = 8'hFF;
    step(); step();
    rst = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_ctrl = 8'h0;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_ctrl", {24'h0, out_ctrl}, 32'h0);
    check("rst_occupancy", {30'h0, occupancy}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_stall", {28'h0, stall_cycles}, 32'h0);
    step();
    check("idle_out_valid", {31'h0, out_valid}, 32'h0);

    // Streaming 1..8 with out_ready held high.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_ctrl = 8'(i + 16);
      exp_q.push_back({8'(i + 16), 32'(i)});
      step();
      check("stream_valid", {31'h0, out_valid}, 32'h1);
      check("stream_data", out_data, 32'(i));
    end
    in_valid = 1'b0;
    step(); step();
    check("stream_drained", {31'h0, out_valid}, 32'h0);
    check("stream_stall", {28'h0, stall_cycles}, 32'h0);

    // Back-pressure: 0xA, 0xB into a stalled stage.
    do_reset();
    in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'h3A;
    exp_q.push_back({8'h3A, 32'hA});
    step();
    in_data = 32'hB; in_ctrl = 8'h3B;
    exp_q.push_back({8'h3B, 32'hB});
    step();
    in_valid = 1'b0; in_data = 32'h0; in_ctrl = 8'h0;
    check("bp_occupancy", {30'h0, occupancy}, 32'h2);
    check("bp_in_ready", {31'h0, in_ready}, 32'h0);
    check("bp_head", out_data, 32'hA);
    step();
    out_ready = 1'b1;
    step();
    check("bp_second", out_data, 32'hB);
    check("bp_occ_one", {30'h0, occupancy}, 32'h1);
    step();
    check("bp_empty", {30'h0, occupancy}, 32'h0);
    check("bp_stall", {28'h0, stall_cycles}, 32'h2);

    // Flush while FULL, with a beat offered in the same cycle.
    do_reset();
    in_valid = 1'b1; in_data = 32'h3; in_ctrl = 8'h03;
    step();
    in_data = 32'h4; in_ctrl = 8'h04;
    step();
    check("fl_full", {30'h0, occupancy}, 32'h2);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hC; in_ctrl = 8'h0C;
    step();
    flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_ctrl = 8'h0;
    check("fl_out_valid", {31'h0, out_valid}, 32'h0);
    check("fl_out_data", out_data, 32'h0);
    check("fl_out_ctrl", {24'h0, out_ctrl}, 32'h0);
    check("fl_occupancy", {30'h0, occupancy}, 32'h0);
    check("fl_in_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    step(); step(); step();
    check("fl_no_0xC", {31'h0, out_valid}, 32'h0);

    // Flush keeps the stall count; reset+flush clears it.
    do_reset();
    in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h55;
    step();
    in_valid = 1'b0; in_data = 32'h0; in_ctrl = 8'h0;
    for (int i = 0; i < 4; i++) step();
    check("st_four", {28'h0, stall_cycles}, 32'h4);
    flush = 1'b1;
    step();
    check("st_flush_five", {28'h0, stall_cycles}, 32'h5);
    check("st_flush_empty", {31'h0, out_valid}, 32'h0);
    step(); step();
    check("st_flush_hold", {28'h0, stall_cycles}, 32'h5);
    rst = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    check("st_rst_clear", {28'h0, stall_cycles}, 32'h0);

    // Saturation of the 4-bit counter.
    do_reset();
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h77;
    step();
    in_valid = 1'b0; in_data = 32'h0; in_ctrl = 8'h0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("sat_count", {28'h0, stall_cycles}, (i > 15) ? 32'd15 : 32'(i));
    end
    do_reset();
    check("sat_rst", {28'h0, stall_cycles}, 32'h0);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
